// File: rtl/mem_copy_engine.sv
// Byte-serial memory copy / fill engine driving a single-port data memory.
// One pointer serves both reads and writes; copy alternates READ/WRITE per byte.
module mem_copy_engine #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Fill,
  input  logic [AW-1:0] SrcAddr,
  input  logic [AW-1:0] DstAddr,
  input  logic [AW-1:0] Length,
  input  logic [DW-1:0] FillValue,
  input  logic [DW-1:0] MemDataOut,
  output logic [AW-1:0] MemAddress,
  output logic [DW-1:0] MemDataIn,
  output logic          MemWriteEn,
  output logic          Busy,
  output logic          Done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_FILL  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW-1:0] len_q, len_d;
  logic [AW-1:0] i_q, i_d;
  logic [DW-1:0] fill_val_q, fill_val_d;
  logic [DW-1:0] data_q, data_d;
  logic [AW-1:0] i_inc;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      i_q        <= '0;
      fill_val_q <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      i_q        <= i_d;
      fill_val_q <= fill_val_d;
      data_q     <= data_d;
    end
  end

  assign i_inc = i_q + AW'(1);

  // Next-state and parameter capture; transfer parameters only load in IDLE.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    i_d        = i_q;
    fill_val_d = fill_val_q;
    data_d     = data_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          src_d      = SrcAddr;
          dst_d      = DstAddr;
          len_d      = Length;
          fill_val_d = FillValue;
          i_d        = '0;
          if (Length == '0) begin
            state_d = S_DONE;
          end else if (Fill) begin
            state_d = S_FILL;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        data_d  = MemDataOut;
        state_d = S_WRITE;
      end
      S_WRITE, S_FILL: begin
        i_d = i_inc;
        if (i_inc >= len_q) begin
          state_d = S_DONE;
        end else if (state_q == S_WRITE) begin
          state_d = S_READ;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Memory-side outputs decoded purely from registered state.
  always_comb begin
    MemAddress = '0;
    MemDataIn  = '0;
    MemWriteEn = 1'b0;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state_q)
      S_READ: begin
        MemAddress = src_q + i_q;
        Busy       = 1'b1;
      end
      S_WRITE: begin
        MemAddress = dst_q + i_q;
        MemDataIn  = data_q;
        MemWriteEn = 1'b1;
        Busy       = 1'b1;
      end
      S_FILL: begin
        MemAddress = dst_q + i_q;
        MemDataIn  = fill_val_q;
        MemWriteEn = 1'b1;
        Busy       = 1'b1;
      end
      S_DONE:  Done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a behavioural 256-byte memory.
module tb_mem_copy_engine;

  logic       Clk;
  logic       Reset;
  logic       Start;
  logic       Fill;
  logic [7:0] SrcAddr;
  logic [7:0] DstAddr;
  logic [7:0] Length;
  logic [7:0] FillValue;
  logic [7:0] MemDataOut;
  logic [7:0] MemAddress;
  logic [7:0] MemDataIn;
  logic       MemWriteEn;
  logic       Busy;
  logic       Done;

  logic [7:0] mem [256];
  logic       ld_en;
  logic [7:0] ld_addr;
  logic [7:0] ld_data;

  int checks = 0;
  int errors = 0;

  mem_copy_engine #(.AW(8), .DW(8)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Fill(Fill),
    .SrcAddr(SrcAddr), .DstAddr(DstAddr), .Length(Length), .FillValue(FillValue),
    .MemDataOut(MemDataOut), .MemAddress(MemAddress), .MemDataIn(MemDataIn),
    .MemWriteEn(MemWriteEn), .Busy(Busy), .Done(Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  assign MemDataOut = mem[MemAddress];

  // DUT writes take priority; the bench preload port is only used while idle.
  always @(posedge Clk) begin
    if (MemWriteEn) mem[MemAddress] <= MemDataIn;
    else if (ld_en) mem[ld_addr] <= ld_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge Clk);
    ld_en = 1'b0;
  endtask

  task automatic start_xfer(input logic f, input logic [7:0] s, input logic [7:0] d,
                            input logic [7:0] n, input logic [7:0] v);
    Start = 1'b1; Fill = f; SrcAddr = s; DstAddr = d; Length = n; FillValue = v;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cycles);
    int n = 0;
    while (!Done && n < max_cycles) begin
      @(negedge Clk);
      n++;
    end
    chk(tag, 32'(Done), 32'd1);
  endtask

  logic [7:0] exp_addr [6];
  int busy_n, done_n, bad_wr;

  initial begin
    Reset = 1'b0; Start = 1'b0; Fill = 1'b0; SrcAddr = '0; DstAddr = '0;
    Length = '0; FillValue = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    #1;
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_done", 32'(Done), 0);
    chk("rst_we",   32'(MemWriteEn), 0);
    chk("rst_addr", 32'(MemAddress), 0);
    chk("rst_din",  32'(MemDataIn), 0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;

    poke(8'h10, 8'hA1); poke(8'h11, 8'hB2); poke(8'h12, 8'hC3);
    poke(8'h40, 8'h00); poke(8'h41, 8'h00); poke(8'h42, 8'h00);
    poke(8'h90, 8'h00);

    // Copy 3 bytes 0x10 -> 0x40
    exp_addr[0] = 8'h10; exp_addr[1] = 8'h40; exp_addr[2] = 8'h11;
    exp_addr[3] = 8'h41; exp_addr[4] = 8'h12; exp_addr[5] = 8'h42;
    start_xfer(1'b0, 8'h10, 8'h40, 8'd3, 8'hEE);
    for (int k = 0; k < 6; k++) begin
      chk("cp_busy", 32'(Busy), 1);
      chk("cp_done", 32'(Done), 0);
      chk("cp_addr", 32'(MemAddress), 32'(exp_addr[k]));
      chk("cp_we",   32'(MemWriteEn), 32'(k % 2));
      if (k == 1) chk("cp_din0", 32'(MemDataIn), 32'hA1);
      if (k == 3) chk("cp_din1", 32'(MemDataIn), 32'hB2);
      if (k == 5) chk("cp_din2", 32'(MemDataIn), 32'hC3);
      @(negedge Clk);
    end
    chk("cp_done_hi",  32'(Done), 1);
    chk("cp_busy_lo",  32'(Busy), 0);
    chk("cp_done_we",  32'(MemWriteEn), 0);
    chk("cp_done_adr", 32'(MemAddress), 0);
    @(negedge Clk);
    chk("cp_done_1cy", 32'(Done), 0);
    chk("cp_mem40", 32'(mem[8'h40]), 32'hA1);
    chk("cp_mem41", 32'(mem[8'h41]), 32'hB2);
    chk("cp_mem42", 32'(mem[8'h42]), 32'hC3);

    // Fill 4 bytes at 0xFE with wrap to 0x01
    exp_addr[0] = 8'hFE; exp_addr[1] = 8'hFF; exp_addr[2] = 8'h00; exp_addr[3] = 8'h01;
    start_xfer(1'b1, 8'h33, 8'hFE, 8'd4, 8'h5A);
    FillValue = 8'h99; DstAddr = 8'h00;
    for (int k = 0; k < 4; k++) begin
      chk("fl_busy", 32'(Busy), 1);
      chk("fl_we",   32'(MemWriteEn), 1);
      chk("fl_addr", 32'(MemAddress), 32'(exp_addr[k]));
      chk("fl_din",  32'(MemDataIn), 32'h5A);
      @(negedge Clk);
    end
    chk("fl_done", 32'(Done), 1);
    chk("fl_busy_lo", 32'(Busy), 0);
    @(negedge Clk);
    chk("fl_memFE", 32'(mem[8'hFE]), 32'h5A);
    chk("fl_memFF", 32'(mem[8'hFF]), 32'h5A);
    chk("fl_mem00", 32'(mem[8'h00]), 32'h5A);
    chk("fl_mem01", 32'(mem[8'h01]), 32'h5A);

    // Zero length
    start_xfer(1'b0, 8'h10, 8'h40, 8'd0, 8'h00);
    chk("z_busy", 32'(Busy), 0);
    chk("z_we",   32'(MemWriteEn), 0);
    chk("z_done", 32'(Done), 1);
    @(negedge Clk);
    chk("z_done_1cy", 32'(Done), 0);

    // Overlapping copy replicates the first source byte
    poke(8'h20, 8'h77); poke(8'h21, 8'h01); poke(8'h22, 8'h02); poke(8'h23, 8'h03);
    start_xfer(1'b0, 8'h20, 8'h21, 8'd3, 8'h00);
    wait_done("ov_done_seen", 20);
    @(negedge Clk);
    chk("ov_mem21", 32'(mem[8'h21]), 32'h77);
    chk("ov_mem22", 32'(mem[8'h22]), 32'h77);
    chk("ov_mem23", 32'(mem[8'h23]), 32'h77);

    // Second Start while busy is ignored
    poke(8'h50, 8'h00); poke(8'h51, 8'h00); poke(8'h52, 8'h00);
    busy_n = 0; done_n = 0; bad_wr = 0;
    Start = 1'b1; Fill = 1'b0; SrcAddr = 8'h10; DstAddr = 8'h50; Length = 8'd3;
    for (int k = 0; k < 10; k++) begin
      @(negedge Clk);
      busy_n += int'(Busy);
      done_n += int'(Done);
      if (MemWriteEn && (MemAddress < 8'h50 || MemAddress > 8'h52)) bad_wr++;
      if (k == 1) begin
        Start = 1'b1; Fill = 1'b1; SrcAddr = 8'h80; DstAddr = 8'h90; Length = 8'd5;
        FillValue = 8'hCC;
      end else begin
        Start = 1'b0;
      end
    end
    chk("sb_busy_cycles", 32'(busy_n), 6);
    chk("sb_done_count",  32'(done_n), 1);
    chk("sb_stray_wr",    32'(bad_wr), 0);
    chk("sb_mem50", 32'(mem[8'h50]), 32'hA1);
    chk("sb_mem51", 32'(mem[8'h51]), 32'hB2);
    chk("sb_mem52", 32'(mem[8'h52]), 32'hC3);
    chk("sb_mem90", 32'(mem[8'h90]), 32'h00);

    // Async reset during the second byte's write of a 4-byte copy
    poke(8'h60, 8'h11); poke(8'h61, 8'h22); poke(8'h62, 8'h33); poke(8'h63, 8'h44);
    poke(8'h70, 8'h00); poke(8'h71, 8'h00); poke(8'h72, 8'h00); poke(8'h73, 8'h00);
    start_xfer(1'b0, 8'h60, 8'h70, 8'd4, 8'h00);
    repeat (3) @(negedge Clk);
    chk("ar_pre_we",   32'(MemWriteEn), 1);
    chk("ar_pre_addr", 32'(MemAddress), 32'h71);
    #2 Reset = 1'b0;
    #1;
    chk("ar_we_drop",   32'(MemWriteEn), 0);
    chk("ar_busy_drop", 32'(Busy), 0);
    chk("ar_addr_zero", 32'(MemAddress), 0);
    @(negedge Clk);
    chk("ar_no_done", 32'(Done), 0);
    Reset = 1'b1;
    Start = 1'b1; Fill = 1'b1; DstAddr = 8'hA0; Length = 8'd2; FillValue = 8'h3C;
    @(negedge Clk);
    Start = 1'b0;
    chk("ar_restart_busy", 32'(Busy), 1);
    chk("ar_mem70", 32'(mem[8'h70]), 32'h11);
    chk("ar_mem71", 32'(mem[8'h71]), 32'h00);
    wait_done("ar_done_seen", 10);
    @(negedge Clk);
    chk("ar_memA0", 32'(mem[8'hA0]), 32'h3C);
    chk("ar_memA1", 32'(mem[8'hA1]), 32'h3C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 Parameter AW, default 8, data-memory address width (256-deep memory).
REQ-002 Parameter DW, default 8, data-memory word width.
REQ-003 Clk  input  1  single clock, all state updates on posedge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 Start  input  1  request pulse, sampled on posedge while idle.
REQ-006 Fill  input  1  mode select, sampled with Start: 0 = copy, 1 = fill.
REQ-007 SrcAddr  input  AW  copy source base address.
REQ-008 DstAddr  input  AW  destination base address (copy and fill).
REQ-009 Length  input  AW  byte count; 0 = no-op.
REQ-010 FillValue  input  DW  constant written in fill mode.
REQ-011 MemDataOut  input  DW  combinational read data from data memory.
REQ-012 MemAddress  output  AW  address to data memory (single pointer, read and write).
REQ-013 MemDataIn  output  DW  write data to data memory.
REQ-014 MemWriteEn  output  1  data-memory write enable.
REQ-015 Busy  output  1  high while a transfer is in progress.
REQ-016 Done  output  1  one-cycle completion pulse.

Function
REQ-017 States: IDLE, READ, WRITE, FILL, DONE; all outputs registered or decoded from registered state only.
REQ-018 IDLE: Start=1 at posedge latches SrcAddr, DstAddr, Length, Fill, FillValue into internal registers and clears byte index i to 0.
REQ-019 IDLE + Start, Length=0: next state DONE, no memory write issued.
REQ-020 IDLE + Start, Length>0: next state READ if Fill=0, FILL if Fill=1.
REQ-021 READ: MemAddress = src+i (mod 256), MemWriteEn=0; at posedge MemDataOut captured into data register; next state WRITE.
REQ-022 WRITE: MemAddress = dst+i (mod 256), MemDataIn = data register, MemWriteEn=1; at posedge i increments; next state READ if i+1 < Length, else DONE.
REQ-023 FILL: MemAddress = dst+i (mod 256), MemDataIn = latched FillValue, MemWriteEn=1; i increments each cycle; leaves to DONE after the Length-th write.
REQ-024 DONE: Done=1, Busy=0, MemWriteEn=0 for exactly one cycle; next state IDLE.
REQ-025 Busy=1 exactly in READ, WRITE, FILL.
REQ-026 Latency: copy of N>0 bytes = 2N busy cycles then Done; fill of N>0 bytes = N busy cycles then Done; Length=0 = Done in cycle after Start.
REQ-027 Address arithmetic is AW-bit modulo: 0xFF+1 wraps to 0x00, no error.
REQ-028 Copy is strictly byte-by-byte ascending; overlapping regions with dst > src replicate source bytes (defined behaviour, not an error).
REQ-029 Start while Busy or in DONE is ignored; latched parameters are not disturbed.
REQ-030 Input changes after the Start cycle have no effect on the transfer in progress.
REQ-031 In IDLE and DONE: MemAddress=0, MemDataIn=0, MemWriteEn=0.
REQ-032 MemWriteEn is never high in READ, IDLE or DONE.

Reset
REQ-033 Reset low forces state IDLE immediately, independent of Clk.
REQ-034 During and after reset: Busy=0, Done=0, MemWriteEn=0, MemAddress=0, MemDataIn=0, i=0, data register=0.
REQ-035 Reset mid-transfer aborts with no further writes; bytes already written remain; no Done pulse is generated.
REQ-036 First Start is accepted on the first posedge after Reset returns high.

Verification
REQ-037 Copy: mem[0x10..0x12]=0xA1,0xB2,0xC3; Start, Fill=0, Src=0x10, Dst=0x40, Len=3 -> 6 Busy cycles, alternating read/write addresses 10,40,11,41,12,42, mem[0x40..0x42]=A1,B2,C3, Done one cycle.
REQ-038 Fill with wrap: Start, Fill=1, Dst=0xFE, Len=4, FillValue=0x5A -> writes at FE,FF,00,01 on 4 consecutive cycles, all 0x5A, then Done.
REQ-039 Zero length: Start, Len=0 -> Busy stays 0, no MemWriteEn, Done high in cycle after Start.
REQ-040 Overlap: mem[0x20]=0x77, Src=0x20, Dst=0x21, Len=3 -> mem[0x21..0x23]=0x77,0x77,0x77.
REQ-041 Start during Busy: second Start with different addresses mid-copy -> ignored, first transfer completes unchanged, single Done.
REQ-042 Async reset: Reset low between posedges in WRITE of byte 2 of a 4-byte copy -> MemWriteEn and Busy drop at once, only byte 1 written, no Done; new Start after release runs normally.
